// File: rtl/menu_ctrl_if.sv
// Front-panel bundle between the button/game-core side and the menu controller.
// The controller takes the slave view; whoever drives the buttons takes the master view.
interface menu_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic       btn_start;
  logic       game_over;
  logic       cursor;
  logic       mode;
  logic [1:0] map;
  logic       start;
  logic       menu_active;

  modport master (
    output btn_up, btn_down, btn_sel, btn_start, game_over,
    input  cursor, mode, map, start, menu_active
  );

  modport slave (
    input  btn_up, btn_down, btn_sel, btn_start, game_over,
    output cursor, mode, map, start, menu_active
  );
endinterface

// File: rtl/menu_ctrl.sv
// Menu controller: debounces four push-buttons, edits cursor/mode/map settings and
// sequences menu -> launch -> run -> wait-for-release around each game.
module menu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  menu_ctrl_if.slave  bus
);

  localparam int NB      = 4;
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_SEL   = 2;
  localparam int B_START = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_MENU     = 2'd0,
    S_LAUNCH   = 2'd1,
    S_RUN      = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  function automatic logic [1:0] map_advance(input logic [1:0] m);
    return (m >= 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync_p0;
  logic [NB-1:0]    sync_p1;
  logic [NB-1:0]    deb_p2;
  logic [NB-1:0]    deb_q_p3;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] cnt_p2 [NB];

  state_t     state_q, state_nxt;
  logic       cursor_q, cursor_nxt;
  logic       mode_q, mode_nxt;
  logic [1:0] map_q, map_nxt;
  logic       start_q;
  logic       menu_active_q;

  assign raw = {bus.btn_start, bus.btn_sel, bus.btn_down, bus.btn_up};

  // Stage p0/p1: two-flop synchronizer for the asynchronous button levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; any cycle where the levels agree restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_p2 <= '0;
      for (int i = 0; i < NB; i++) cnt_p2[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] != deb_p2[i]) begin
          if (cnt_p2[i] == CNT_LAST) begin
            deb_p2[i] <= sync_p1[i];
            cnt_p2[i] <= '0;
          end else begin
            cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
          end
        end else begin
          cnt_p2[i] <= '0;
        end
      end
    end
  end

  // Stage p3: edge register, press is a one-cycle debounced rising edge
  always_ff @(posedge clk) begin
    if (rst) deb_q_p3 <= '0;
    else     deb_q_p3 <= deb_p2;
  end

  assign press = deb_p2 & ~deb_q_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_MENU;
      cursor_q      <= 1'b0;
      mode_q        <= 1'b0;
      map_q         <= 2'd0;
      start_q       <= 1'b0;
      menu_active_q <= 1'b1;
    end else begin
      state_q       <= state_nxt;
      cursor_q      <= cursor_nxt;
      mode_q        <= mode_nxt;
      map_q         <= map_nxt;
      start_q       <= (state_q == S_LAUNCH);
      menu_active_q <= (state_q == S_MENU);
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cursor_nxt = cursor_q;
    mode_nxt   = mode_q;
    map_nxt    = map_q;
    unique case (state_q)
      S_MENU: begin
        // Priority start > sel > up/down; up and down together cancel out
        if (press[B_START]) begin
          state_nxt = S_LAUNCH;
        end else if (press[B_SEL]) begin
          if (cursor_q) map_nxt  = map_advance(map_q);
          else          mode_nxt = ~mode_q;
        end else if (press[B_UP] ^ press[B_DOWN]) begin
          cursor_nxt = press[B_DOWN];
        end
      end
      S_LAUNCH:   state_nxt = S_RUN;
      S_RUN:      if (bus.game_over) state_nxt = S_WAIT_REL;
      S_WAIT_REL: if (deb_p2 == '0) state_nxt = S_MENU;
      default:    state_nxt = S_MENU;
    endcase
  end

  assign bus.cursor      = cursor_q;
  assign bus.mode        = mode_q;
  assign bus.map         = map_q;
  assign bus.start       = start_q;
  assign bus.menu_active = menu_active_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with a 4-cycle debounce window; inputs change and
// outputs are sampled on the falling clock edge.
module tb_menu_ctrl;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  menu_ctrl_if bus ();

  menu_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mask bits: 0 up, 1 down, 2 sel, 3 start
  task automatic set_btn(input logic [3:0] m);
    bus.btn_up    = m[0];
    bus.btn_down  = m[1];
    bus.btn_sel   = m[2];
    bus.btn_start = m[3];
  endtask

  task automatic press_btn(input logic [3:0] m);
    set_btn(m);
    cyc(10);
    set_btn(4'b0000);
    cyc(10);
  endtask

  // Raw rise sampled at edge 1, start high after edge 4+D = 8 for one cycle
  task automatic launch(input logic [3:0] m, input string tag);
    set_btn(m);
    cyc(7);
    chk({tag, "_start_pre"}, 32'(bus.start), 32'd0);
    chk({tag, "_menu_pre"}, 32'(bus.menu_active), 32'd1);
    cyc(1);
    chk({tag, "_start_hi"}, 32'(bus.start), 32'd1);
    chk({tag, "_menu_lo"}, 32'(bus.menu_active), 32'd0);
    cyc(1);
    chk({tag, "_start_post"}, 32'(bus.start), 32'd0);
    set_btn(4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    bus.game_over = 1'b0;
    set_btn(4'b1111);
    cyc(2);
    // 1. reset with all buttons held
    chk("rst_cursor", 32'(bus.cursor), 32'd0);
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_map", 32'(bus.map), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_menu", 32'(bus.menu_active), 32'd1);
    rst = 1'b0;
    set_btn(4'b0000);
    cyc(12);
    chk("post_rst_cursor", 32'(bus.cursor), 32'd0);
    chk("post_rst_mode", 32'(bus.mode), 32'd0);
    chk("post_rst_map", 32'(bus.map), 32'd0);
    chk("post_rst_menu", 32'(bus.menu_active), 32'd1);

    // 2. short burst ignored, long press toggles mode at edge 7 after rise
    set_btn(4'b0100);
    cyc(3);
    set_btn(4'b0000);
    cyc(1);
    set_btn(4'b0100);
    cyc(6);
    chk("deb_mode_early", 32'(bus.mode), 32'd0);
    cyc(1);
    chk("deb_mode_toggle", 32'(bus.mode), 32'd1);
    set_btn(4'b0000);
    cyc(10);

    // 3. navigation and map wrap
    press_btn(4'b0010);
    chk("nav_down", 32'(bus.cursor), 32'd1);
    press_btn(4'b0100);
    chk("map_1", 32'(bus.map), 32'd1);
    press_btn(4'b0100);
    chk("map_2", 32'(bus.map), 32'd2);
    press_btn(4'b0100);
    chk("map_wrap_0", 32'(bus.map), 32'd0);
    press_btn(4'b0100);
    chk("map_1b", 32'(bus.map), 32'd1);
    chk("map_mode_kept", 32'(bus.mode), 32'd1);
    press_btn(4'b0010);
    chk("nav_down_sat", 32'(bus.cursor), 32'd1);
    press_btn(4'b0001);
    chk("nav_up", 32'(bus.cursor), 32'd0);
    press_btn(4'b0001);
    chk("nav_up_sat", 32'(bus.cursor), 32'd0);

    // 4. simultaneous events
    press_btn(4'b0011);
    chk("updown_cursor", 32'(bus.cursor), 32'd0);
    launch(4'b1100, "startsel");
    chk("startsel_mode", 32'(bus.mode), 32'd1);
    chk("startsel_map", 32'(bus.map), 32'd1);
    bus.game_over = 1'b1;
    cyc(12);
    bus.game_over = 1'b0;
    chk("startsel_back_menu", 32'(bus.menu_active), 32'd1);
    chk("startsel_mode_after", 32'(bus.mode), 32'd1);
    chk("startsel_map_after", 32'(bus.map), 32'd1);
    cyc(10);

    // 5. full game cycle with presses discarded in RUN
    launch(4'b1000, "game");
    cyc(10);
    press_btn(4'b0100);
    press_btn(4'b0001);
    chk("run_mode", 32'(bus.mode), 32'd1);
    chk("run_map", 32'(bus.map), 32'd1);
    chk("run_cursor", 32'(bus.cursor), 32'd0);
    chk("run_menu", 32'(bus.menu_active), 32'd0);
    set_btn(4'b0100);
    cyc(10);
    bus.game_over = 1'b1;
    cyc(5);
    bus.game_over = 1'b0;
    chk("waitrel_held", 32'(bus.menu_active), 32'd0);
    set_btn(4'b0000);
    cyc(6);
    chk("waitrel_not_yet", 32'(bus.menu_active), 32'd0);
    cyc(3);
    chk("waitrel_menu", 32'(bus.menu_active), 32'd1);
    chk("waitrel_mode", 32'(bus.mode), 32'd1);
    chk("waitrel_map", 32'(bus.map), 32'd1);
    chk("waitrel_cursor", 32'(bus.cursor), 32'd0);
    cyc(10);
    chk("reentry_mode", 32'(bus.mode), 32'd1);

    // 6. reset while sel is two samples into its debounce count
    set_btn(4'b0100);
    cyc(4);
    rst = 1'b1;
    set_btn(4'b0000);
    cyc(1);
    rst = 1'b0;
    chk("midrst_mode", 32'(bus.mode), 32'd0);
    chk("midrst_map", 32'(bus.map), 32'd0);
    cyc(12);
    chk("midrst_no_event", 32'(bus.mode), 32'd0);
    press_btn(4'b0100);
    chk("midrst_full_press", 32'(bus.mode), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
